// File: rtl/serial_port_pkg.sv
// Shared register map, STATUS layout and size limits for the serial FIFO port.
package serial_port_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1
  } reg_addr_e;

  localparam int BUS_W = 32;

  localparam int STAT_RX_NOT_EMPTY = 0;
  localparam int STAT_TX_NOT_FULL  = 1;
  localparam int STAT_RX_FULL      = 2;
  localparam int STAT_TX_EMPTY     = 3;
  localparam int STAT_OVERRUN      = 4;
  localparam int STAT_RX_COUNT_LSB = 8;
  localparam int STAT_TX_COUNT_LSB = 16;
  localparam int COUNT_FIELD_W     = 8;

  localparam int MIN_DATA_W = 1;
  localparam int MAX_DATA_W = 8;
  localparam int MIN_DEPTH  = 2;
  localparam int MAX_DEPTH  = 128;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; head reads as zero when empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    // Simultaneous push and pop leaves the occupancy unchanged.
    if (do_push && !do_pop) count_d = count_q + CNT_ONE;
    if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/serial_fifo_port.sv
// Memory-mapped serial port with RX/TX FIFOs and a STATUS register.
// Define SERIAL_FIFO_OVERRUN_EN to accept bytes unconditionally and flag RX overrun.
module serial_fifo_port
  import serial_port_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        addr_in,
  input  logic [31:0]       writedata_in,
  input  logic              re_in,
  input  logic              we_in,
  output logic [31:0]       readdata_out,
  output logic              rx_irq_out,
  input  logic [DATA_W-1:0] serial_in,
  input  logic              serial_valid_in,
  output logic              serial_rden_out,
  input  logic              serial_ready_in,
  output logic [DATA_W-1:0] serial_out,
  output logic              serial_wren_out
);

  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_head;
  logic [RX_CW-1:0]  rx_count;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic [TX_CW-1:0]  tx_count;
  logic              data_sel, status_sel, status_rd, overrun;
  logic [BUS_W-1:0]  status_w;
  logic              unused_wdata;

  assign unused_wdata = &{1'b0, writedata_in};

  assign data_sel   = (addr_in == REG_DATA);
  assign status_sel = (addr_in == REG_STATUS);
  assign status_rd  = re_in & status_sel;

  // Serial handshake: a byte moves on any cycle where its enable is high;
  // enables depend only on registered FIFO state and the external qualifier.
`ifdef SERIAL_FIFO_OVERRUN_EN
  logic overrun_q, overrun_d;

  assign serial_rden_out = serial_valid_in & reset;

  always_comb begin
    overrun_d = overrun_q;
    if (status_rd) overrun_d = 1'b0;
    if (serial_valid_in && rx_full) overrun_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign serial_rden_out = serial_valid_in & ~rx_full & reset;
  assign overrun         = 1'b0;
`endif

  assign rx_push = serial_rden_out & ~rx_full;
  assign rx_pop  = re_in & data_sel & ~rx_empty;
  assign tx_push = we_in & data_sel & ~tx_full;

  assign serial_wren_out = serial_ready_in & ~tx_empty;
  assign tx_pop          = serial_wren_out;
  assign serial_out      = tx_head;
  assign rx_irq_out      = ~rx_empty | overrun;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (clock),
    .rst_n  (reset),
    .push_i (rx_push),
    .pop_i  (rx_pop),
    .din_i  (serial_in),
    .dout_o (rx_head),
    .count_o(rx_count),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clock),
    .rst_n  (reset),
    .push_i (tx_push),
    .pop_i  (tx_pop),
    .din_i  (writedata_in[DATA_W-1:0]),
    .dout_o (tx_head),
    .count_o(tx_count),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

  always_comb begin
    status_w = '0;
    status_w[STAT_RX_NOT_EMPTY] = ~rx_empty;
    status_w[STAT_TX_NOT_FULL]  = ~tx_full;
    status_w[STAT_RX_FULL]      = rx_full;
    status_w[STAT_TX_EMPTY]     = tx_empty;
    status_w[STAT_OVERRUN]      = overrun;
    status_w[STAT_RX_COUNT_LSB +: COUNT_FIELD_W] = COUNT_FIELD_W'(rx_count);
    status_w[STAT_TX_COUNT_LSB +: COUNT_FIELD_W] = COUNT_FIELD_W'(tx_count);
  end

  always_comb begin
    readdata_out = '0;
    case (addr_in)
      REG_DATA:   readdata_out = BUS_W'(rx_head);
      REG_STATUS: readdata_out = status_w;
      default:    readdata_out = '0;
    endcase
  end

endmodule

// File: tb/tb_serial_fifo_port.sv
// Directed bench for serial_fifo_port at DATA_W=8, depth 4/4.
module tb_serial_fifo_port;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [1:0]    addr;
  logic [31:0]   wdata, rdata;
  logic          re, we, irq;
  logic [DW-1:0] s_in, s_out;
  logic          s_valid, s_rden, s_ready, s_wren;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  serial_fifo_port #(.DATA_W(DW), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .addr_in        (addr),
    .writedata_in   (wdata),
    .re_in          (re),
    .we_in          (we),
    .readdata_out   (rdata),
    .rx_irq_out     (irq),
    .serial_in      (s_in),
    .serial_valid_in(s_valid),
    .serial_rden_out(s_rden),
    .serial_ready_in(s_ready),
    .serial_out     (s_out),
    .serial_wren_out(s_wren)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic cpu_read_data(output logic [31:0] d);
    addr = 2'd0; re = 1'b1;
    #1 d = rdata;
    step();
    re = 1'b0;
  endtask

  task automatic peek_status(output logic [31:0] s);
    addr = 2'd1;
    #1 s = rdata;
  endtask

  task automatic serial_push(input logic [7:0] b);
    s_in = b; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_in = 8'h99; s_ready = 1'b1;
    re = 1'b0; we = 1'b0; addr = 2'd1; wdata = 32'h0;
    step();
    step();
    #1;
    total_cnt++; if (s_rden !== 1'b0) $display("FAIL reset_rden got %0b exp 0", s_rden); else pass_cnt++;
    total_cnt++; if (s_wren !== 1'b0) $display("FAIL reset_wren got %0b exp 0", s_wren); else pass_cnt++;
    total_cnt++; if (s_out !== 8'h00) $display("FAIL reset_sout got %h exp 00", s_out); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq got %0b exp 0", irq); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0000_000A) $display("FAIL reset_status got %h exp 0000000a", rdata); else pass_cnt++;
    addr = 2'd0;
    #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_data got %h exp 0", rdata); else pass_cnt++;
    s_valid = 1'b0; s_ready = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rx_burst();
    logic [7:0]  vec [5];
    logic [31:0] d;
    vec = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int c = 0; c < 6; c++) begin
      s_in = vec[(c < 4) ? c : 4]; s_valid = 1'b1;
      #1;
      total_cnt++;
      if (s_rden !== (c < 4)) $display("FAIL rx_burst_rden cycle %0d got %0b exp %0b", c, s_rden, (c < 4));
      else pass_cnt++;
      if (c < 4) exp_q.push_back(vec[c]);
      step();
    end
    s_valid = 1'b0;
    peek_status(d);
    total_cnt++; if (d !== 32'h0000_040F) $display("FAIL rx_burst_status got %h exp 0000040f", d); else pass_cnt++;
    total_cnt++; if (irq !== 1'b1) $display("FAIL rx_burst_irq got %0b exp 1", irq); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      cpu_read_data(d);
      total_cnt++; if (d !== {24'h0, e}) $display("FAIL rx_burst_read %0d got %h exp %h", i, d, e); else pass_cnt++;
    end
    peek_status(d);
    total_cnt++; if (d !== 32'h0000_000A) $display("FAIL rx_drained_status got %h exp 0000000a", d); else pass_cnt++;
    s_in = 8'h55; s_valid = 1'b1;
    #1;
    total_cnt++; if (s_rden !== 1'b1) $display("FAIL rx_rden_again got %0b exp 1", s_rden); else pass_cnt++;
    step();
    s_valid = 1'b0;
    cpu_read_data(d);
    total_cnt++; if (d !== 32'h55) $display("FAIL rx_read_55 got %h exp 00000055", d); else pass_cnt++;
    cpu_read_data(d);
    total_cnt++; if (d !== 32'h0) $display("FAIL rx_empty_read got %h exp 0", d); else pass_cnt++;
    peek_status(d);
    total_cnt++; if (d !== 32'h0000_000A) $display("FAIL rx_empty_status got %h exp 0000000a", d); else pass_cnt++;
  endtask

  task automatic test_tx();
    logic [31:0] d;
    s_ready = 1'b0;
    cpu_write(2'd0, 32'hFFFF_FFA5);
    cpu_write(2'd0, 32'h1234_565A);
    peek_status(d);
    total_cnt++; if (d[23:16] !== 8'd2) $display("FAIL tx_count got %0d exp 2", d[23:16]); else pass_cnt++;
    total_cnt++; if (s_wren !== 1'b0) $display("FAIL tx_wren_not_ready got %0b exp 0", s_wren); else pass_cnt++;
    s_ready = 1'b1;
    #1;
    total_cnt++; if (s_wren !== 1'b1 || s_out !== 8'hA5) $display("FAIL tx_first got wren=%0b out=%h exp 1/a5", s_wren, s_out); else pass_cnt++;
    step();
    #1;
    total_cnt++; if (s_wren !== 1'b1 || s_out !== 8'h5A) $display("FAIL tx_second got wren=%0b out=%h exp 1/5a", s_wren, s_out); else pass_cnt++;
    step();
    peek_status(d);
    total_cnt++; if (s_wren !== 1'b0 || s_out !== 8'h00) $display("FAIL tx_idle got wren=%0b out=%h exp 0/00", s_wren, s_out); else pass_cnt++;
    total_cnt++; if (d !== 32'h0000_000A) $display("FAIL tx_empty_status got %h exp 0000000a", d); else pass_cnt++;
    s_ready = 1'b0;
  endtask

  task automatic test_simul_rx();
    logic [31:0] d;
    serial_push(8'h01); exp_q.push_back(8'h01);
    serial_push(8'h02); exp_q.push_back(8'h02);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'(8'h10 + i);
      s_in = b; s_valid = 1'b1; addr = 2'd0; re = 1'b1;
      #1;
      total_cnt++;
      if (rdata !== {24'h0, exp_q[0]} || s_rden !== 1'b1)
        $display("FAIL simul_rx iter %0d got data=%h rden=%0b exp %h/1", i, rdata, s_rden, exp_q[0]);
      else pass_cnt++;
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(b);
    end
    s_valid = 1'b0; re = 1'b0;
    peek_status(d);
    total_cnt++; if (d[15:8] !== 8'd2) $display("FAIL simul_rx_count got %0d exp 2", d[15:8]); else pass_cnt++;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      cpu_read_data(d);
      total_cnt++; if (d !== {24'h0, e}) $display("FAIL simul_rx_drain got %h exp %h", d, e); else pass_cnt++;
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] d;
    s_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_write(2'd0, 32'(8'hC1 + i));
      exp_q.push_back(8'(8'hC1 + i));
    end
    cpu_write(2'd0, 32'h0000_00FF);
    peek_status(d);
    total_cnt++; if (d[23:16] !== 8'd4 || d[1] !== 1'b0) $display("FAIL tx_full_status got %h exp count 4 not_full 0", d); else pass_cnt++;
    s_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      #1;
      total_cnt++; if (s_wren !== 1'b1 || s_out !== e) $display("FAIL tx_full_drain %0d got wren=%0b out=%h exp 1/%h", i, s_wren, s_out, e); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (s_wren !== 1'b0 || s_out !== 8'h00) $display("FAIL tx_full_after got wren=%0b out=%h exp 0/00", s_wren, s_out); else pass_cnt++;
    s_ready = 1'b0;
  endtask

  task automatic test_reserved();
    logic [31:0] d;
    serial_push(8'h66);
    addr = 2'd2; re = 1'b1; we = 1'b1; wdata = 32'h77;
    #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL reserved2_read got %h exp 0", rdata); else pass_cnt++;
    step();
    addr = 2'd3;
    #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL reserved3_read got %h exp 0", rdata); else pass_cnt++;
    step();
    re = 1'b0; we = 1'b0;
    peek_status(d);
    total_cnt++; if (d !== 32'h0000_010B) $display("FAIL reserved_status got %h exp 0000010b", d); else pass_cnt++;
    cpu_read_data(d);
    total_cnt++; if (d !== 32'h66) $display("FAIL reserved_rx_kept got %h exp 00000066", d); else pass_cnt++;
  endtask

  task automatic test_both_strobes();
    logic [31:0] d;
    serial_push(8'h3C);
    s_ready = 1'b0;
    addr = 2'd0; re = 1'b1; we = 1'b1; wdata = 32'h44;
    #1;
    total_cnt++; if (rdata !== 32'h3C) $display("FAIL both_read got %h exp 0000003c", rdata); else pass_cnt++;
    step();
    re = 1'b0; we = 1'b0;
    peek_status(d);
    total_cnt++; if (d !== 32'h0001_0002) $display("FAIL both_status got %h exp 00010002", d); else pass_cnt++;
    s_ready = 1'b1;
    #1;
    total_cnt++; if (s_out !== 8'h44 || s_wren !== 1'b1) $display("FAIL both_tx got out=%h wren=%0b exp 44/1", s_out, s_wren); else pass_cnt++;
    step();
    s_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_out [5];
    logic       exp_wr  [5];
    exp_out = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h00};
    exp_wr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    s_ready = 1'b1; addr = 2'd0;
    for (int c = 0; c < 5; c++) begin
      we = (c < 3); wdata = 32'(8'h31 + c);
      #1;
      total_cnt++;
      if (s_wren !== exp_wr[c] || s_out !== exp_out[c])
        $display("FAIL b2b cycle %0d got wren=%0b out=%h exp %0b/%h", c, s_wren, s_out, exp_wr[c], exp_out[c]);
      else pass_cnt++;
      step();
    end
    we = 1'b0; s_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      serial_push(8'(8'h80 + i));
      exp_q.push_back(8'(8'h80 + i));
    end
    s_in = 8'h99; s_valid = 1'b1;
    #1;
`ifdef SERIAL_FIFO_OVERRUN_EN
    total_cnt++; if (s_rden !== 1'b1) $display("FAIL ovr_rden got %0b exp 1", s_rden); else pass_cnt++;
    step();
    s_valid = 1'b0;
    peek_status(d);
    total_cnt++; if (d !== 32'h0000_041F || irq !== 1'b1) $display("FAIL ovr_set got %h irq=%0b exp 0000041f/1", d, irq); else pass_cnt++;
    addr = 2'd1; re = 1'b1; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    peek_status(d);
    total_cnt++; if (d[4] !== 1'b1) $display("FAIL ovr_set_wins got %0b exp 1", d[4]); else pass_cnt++;
    step();
    re = 1'b0;
    peek_status(d);
    total_cnt++; if (d !== 32'h0000_040F) $display("FAIL ovr_clear got %h exp 0000040f", d); else pass_cnt++;
`else
    total_cnt++; if (s_rden !== 1'b0) $display("FAIL bp_rden got %0b exp 0", s_rden); else pass_cnt++;
    step();
    s_valid = 1'b0;
    peek_status(d);
    total_cnt++; if (d !== 32'h0000_040F || irq !== 1'b1) $display("FAIL bp_status got %h irq=%0b exp 0000040f/1", d, irq); else pass_cnt++;
`endif
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      cpu_read_data(d);
      total_cnt++; if (d !== {24'h0, e}) $display("FAIL ovr_drain got %h exp %h", d, e); else pass_cnt++;
    end
    #1;
    total_cnt++; if (irq !== 1'b0) $display("FAIL ovr_irq_low got %0b exp 0", irq); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    serial_push(8'hE1); serial_push(8'hE2); serial_push(8'hE3);
    s_ready = 1'b0;
    cpu_write(2'd0, 32'hD1);
    cpu_write(2'd0, 32'hD2);
    peek_status(d);
    total_cnt++; if (d !== 32'h0002_0303) $display("FAIL mid_pre_status got %h exp 00020303", d); else pass_cnt++;
    addr = 2'd0; re = 1'b1; we = 1'b1; wdata = 32'hBB; s_in = 8'hCC; s_valid = 1'b1; s_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (s_rden !== 1'b0 || s_wren !== 1'b0 || s_out !== 8'h00 || irq !== 1'b0 || rdata !== 32'h0)
      $display("FAIL mid_reset_outs got rden=%0b wren=%0b out=%h irq=%0b data=%h exp all 0", s_rden, s_wren, s_out, irq, rdata);
    else pass_cnt++;
    step();
    addr = 2'd1;
    #1;
    total_cnt++; if (rdata !== 32'h0000_000A) $display("FAIL mid_reset_status got %h exp 0000000a", rdata); else pass_cnt++;
    re = 1'b0; we = 1'b0; s_valid = 1'b0; s_ready = 1'b0;
    rst_n = 1'b1;
    step();
    peek_status(d);
    total_cnt++; if (d !== 32'h0000_000A) $display("FAIL mid_after_status got %h exp 0000000a", d); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rx_burst();
    test_tx();
    test_simul_rx();
    test_tx_full();
    test_reserved();
    test_both_strobes();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
